// File: rtl/mem_unit_pkg.sv
// Shared types for the data-side memory unit: load/store size encoding,
// cache controller states and address-split widths.
package mem_unit_pkg;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WB,
    S_REFILL,
    S_FLUSH
  } state_e;

  localparam int unsigned OFF_W = 2;
  localparam int unsigned WAYS  = 2;

endpackage

// File: rtl/lsu_align.sv
// Load extraction/extension, store byte-merge and misalignment check for one word.
module lsu_align
  import mem_unit_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [OFF_W-1:0] offset,
  input  logic [XLEN-1:0] line_data,
  input  logic [XLEN-1:0] store_data,
  output logic            legal_c,
  output logic            misaligned_c,
  output logic [XLEN-1:0] load_data_c,
  output logic [XLEN-1:0] merged_data_c
);

  logic [OFF_W+2:0] sh;
  logic [XLEN-1:0]  shifted;
  logic [XLEN-1:0]  mask;

  always_comb begin
    legal_c       = 1'b0;
    misaligned_c  = 1'b0;
    load_data_c   = '0;
    mask          = '0;
    sh            = {offset, 3'b000};
    shifted       = line_data >> sh;

    case (funct3)
      F3_B, F3_BU: legal_c = 1'b1;
      F3_H, F3_HU: begin
        misaligned_c = offset[0];
        legal_c      = ~offset[0];
      end
      F3_W: begin
        misaligned_c = (offset != '0);
        legal_c      = (offset == '0);
      end
      default: ;
    endcase

    if (legal_c) begin
      case (funct3)
        F3_B:    load_data_c = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
        F3_BU:   load_data_c = {{(XLEN-8){1'b0}}, shifted[7:0]};
        F3_H:    load_data_c = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
        F3_HU:   load_data_c = {{(XLEN-16){1'b0}}, shifted[15:0]};
        default: load_data_c = line_data;
      endcase
      case (funct3)
        F3_B, F3_BU: mask = XLEN'(8'hFF) << sh;
        F3_H, F3_HU: mask = XLEN'(16'hFFFF) << sh;
        default:     mask = '1;
      endcase
    end

    // Unchanged lanes keep the line contents; selected lanes take the shifted store data.
    merged_data_c = (line_data & ~mask) | ((store_data << sh) & mask);
  end

endmodule

// File: rtl/assoc_memory_unit.sv
// 2-way set-associative write-back/write-allocate data cache with LRU
// replacement, explicit flush and a valid/ready backing-memory port.
module assoc_memory_unit
  import mem_unit_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned SETS = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            re,
  input  logic            we,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  input  logic [2:0]      funct3,
  input  logic            flush,
  output logic [XLEN-1:0] rdata,
  output logic            stall,
  output logic            misaligned,
  output logic            flush_done,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready
);

  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TAG_W = XLEN - IDX_W - OFF_W;

  state_e            state_q, state_d;
  logic [SETS-1:0]   valid_q [WAYS];
  logic [SETS-1:0]   dirty_q [WAYS];
  logic [SETS-1:0]   lru_q;
  logic [TAG_W-1:0]  tag_q  [WAYS][SETS];
  logic [XLEN-1:0]   data_q [WAYS][SETS];
  logic              victim_q;
  logic              flushing_q;
  logic [IDX_W-1:0]  fl_set_q;
  logic              fl_way_q;
  logic              flush_done_q;

  logic [IDX_W-1:0]  idx, wb_set;
  logic [TAG_W-1:0]  tag;
  logic              hit0, hit1, hit, hit_way, victim_c, wb_way, fl_last, access;
  logic              legal_c, mis_c;
  logic [XLEN-1:0]   load_c, store_c;
  logic              hit_upd, refill_upd, wb_done, fl_adv, fl_finish, miss_start, flush_start;

  assign idx      = addr[IDX_W+OFF_W-1:OFF_W];
  assign tag      = addr[XLEN-1:IDX_W+OFF_W];
  assign hit0     = valid_q[0][idx] && (tag_q[0][idx] == tag);
  assign hit1     = valid_q[1][idx] && (tag_q[1][idx] == tag);
  assign hit      = hit0 | hit1;
  assign hit_way  = ~hit0;
  assign victim_c = !valid_q[0][idx] ? 1'b0 : (!valid_q[1][idx] ? 1'b1 : lru_q[idx]);
  assign access   = (re | we) && legal_c;
  // Write-back source is the flush cursor while flushing, else the miss victim.
  assign wb_set   = flushing_q ? fl_set_q : idx;
  assign wb_way   = flushing_q ? fl_way_q : victim_q;
  assign fl_last  = (fl_set_q == IDX_W'(SETS-1)) && fl_way_q;
  assign flush_done = flush_done_q;

  lsu_align #(.XLEN(XLEN)) u_align (
    .funct3        (funct3),
    .offset        (addr[OFF_W-1:0]),
    .line_data     (data_q[hit_way][idx]),
    .store_data    (wdata),
    .legal_c       (legal_c),
    .misaligned_c  (mis_c),
    .load_data_c   (load_c),
    .merged_data_c (store_c)
  );

  always_comb begin
    state_d     = state_q;
    stall       = 1'b0;
    rdata       = '0;
    misaligned  = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    hit_upd     = 1'b0;
    refill_upd  = 1'b0;
    wb_done     = 1'b0;
    fl_adv      = 1'b0;
    fl_finish   = 1'b0;
    miss_start  = 1'b0;
    flush_start = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (flush) begin
          stall       = 1'b1;
          flush_start = 1'b1;
          state_d     = S_FLUSH;
        end else begin
          misaligned = (re | we) && mis_c;
          if (access && hit) begin
            hit_upd = 1'b1;
            if (!we) rdata = load_c;
          end else if (access) begin
            stall      = 1'b1;
            miss_start = 1'b1;
            state_d    = (valid_q[victim_c][idx] && dirty_q[victim_c][idx]) ? S_WB : S_REFILL;
          end
        end
      end
      S_WB: begin
        stall     = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {tag_q[wb_way][wb_set], wb_set, 2'b00};
        mem_wdata = data_q[wb_way][wb_set];
        if (mem_ready) begin
          wb_done = 1'b1;
          if (!flushing_q) begin
            state_d = S_REFILL;
          end else if (fl_last) begin
            fl_finish = 1'b1;
            state_d   = S_IDLE;
          end else begin
            fl_adv  = 1'b1;
            state_d = S_FLUSH;
          end
        end
      end
      S_REFILL: begin
        stall    = 1'b1;
        mem_req  = 1'b1;
        mem_addr = {tag, idx, 2'b00};
        if (mem_ready) begin
          refill_upd = 1'b1;
          state_d    = S_IDLE;
        end
      end
      S_FLUSH: begin
        stall = 1'b1;
        if (valid_q[fl_way_q][fl_set_q] && dirty_q[fl_way_q][fl_set_q]) begin
          state_d = S_WB;
        end else if (fl_last) begin
          fl_finish = 1'b1;
          state_d   = S_IDLE;
        end else begin
          fl_adv = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state and line metadata.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      valid_q      <= '{default: '0};
      dirty_q      <= '{default: '0};
      lru_q        <= '0;
      victim_q     <= 1'b0;
      flushing_q   <= 1'b0;
      fl_set_q     <= '0;
      fl_way_q     <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_done_q <= fl_finish;
      if (miss_start) victim_q <= victim_c;
      if (flush_start) begin
        flushing_q <= 1'b1;
        fl_set_q   <= '0;
        fl_way_q   <= 1'b0;
      end
      if (fl_adv) begin
        fl_way_q <= ~fl_way_q;
        if (fl_way_q) fl_set_q <= fl_set_q + IDX_W'(1);
      end
      if (fl_finish) flushing_q <= 1'b0;
      if (hit_upd) begin
        lru_q[idx] <= ~hit_way;
        if (we) dirty_q[hit_way][idx] <= 1'b1;
      end
      if (refill_upd) begin
        valid_q[victim_q][idx] <= 1'b1;
        dirty_q[victim_q][idx] <= 1'b0;
      end
      if (wb_done) dirty_q[wb_way][wb_set] <= 1'b0;
    end
  end

  // Tag and data arrays need no reset; valid bits qualify them.
  always_ff @(posedge clk) begin
    if (refill_upd) begin
      data_q[victim_q][idx] <= mem_rdata;
      tag_q[victim_q][idx]  <= tag;
    end else if (hit_upd && we) begin
      data_q[hit_way][idx] <= store_c;
    end
  end

endmodule

// File: tb/tb_assoc_memory_unit.sv
// Directed bench for assoc_memory_unit with a latency-configurable memory responder.
module tb_assoc_memory_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        re = 1'b0, we = 1'b0, flush = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [2:0]  funct3 = '0;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic        stall, misaligned, flush_done, mem_req, mem_we;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;

  int          n_checks = 0;
  int          n_errors = 0;
  int          mem_lat = 2;
  int          wait_cnt = 0;
  int          rd_cnt = 0;
  logic [31:0] last_rd = '0;
  logic [31:0] wb_addr_q[$];
  logic [31:0] wb_data_q[$];
  logic [31:0] mem [logic [31:0]];

  assoc_memory_unit #(.XLEN(32), .SETS(16)) dut (
    .clk(clk), .rst_n(rst_n), .re(re), .we(we), .addr(addr), .wdata(wdata),
    .funct3(funct3), .flush(flush), .rdata(rdata), .stall(stall),
    .misaligned(misaligned), .flush_done(flush_done), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  // Backing memory: accepts a request mem_lat cycles after it first appears.
  always @(negedge clk) begin
    if (mem_ready) begin
      mem_ready <= 1'b0;
      wait_cnt  <= 0;
    end else if (mem_req) begin
      if (wait_cnt >= mem_lat) begin
        mem_ready <= 1'b1;
        if (mem_we) begin
          wb_addr_q.push_back(mem_addr);
          wb_data_q.push_back(mem_wdata);
          mem[mem_addr] = mem_wdata;
        end else begin
          mem_rdata <= mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
          last_rd   <= mem_addr;
          rd_cnt++;
        end
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present one access at a negedge and wait (bounded) until stall drops.
  task automatic access(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [2:0] f, output int stalls);
    re = r; we = w; addr = a; wdata = d; funct3 = f;
    stalls = 0;
    #1;
    while (stall && stalls < 100) begin
      @(negedge clk);
      #1;
      stalls++;
    end
    if (stalls >= 100) check("stall_timeout", 32'(stall), 32'h0);
  endtask

  task automatic release_bus();
    @(negedge clk);
    re = 1'b0; we = 1'b0;
  endtask

  initial begin
    int st, wb0, rd0, pulses;

    mem[32'h100] = 32'hDEADBEEF;
    mem[32'h140] = 32'h11112222;
    mem[32'h180] = 32'h33334444;
    mem[32'h1C0] = 32'h55556666;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_stall", 32'(stall), 32'h0);
    check("rst_mem_req", 32'(mem_req), 32'h0);
    check("rst_flush_done", 32'(flush_done), 32'h0);
    check("rst_rdata", rdata, 32'h0);
    @(negedge clk);

    // Cold miss: 1 miss cycle + 3 refill cycles with a 2-cycle memory wait.
    access(1, 0, 32'h100, 0, 3'b010, st);
    check("lw_miss_stalls", 32'(st), 32'd4);
    check("lw_miss_rdata", rdata, 32'hDEADBEEF);
    check("lw_miss_rd_addr", last_rd, 32'h100);
    release_bus();

    access(1, 0, 32'h100, 0, 3'b010, st);
    check("lw_hit_stalls", 32'(st), 32'd0);
    check("lw_hit_rdata", rdata, 32'hDEADBEEF);
    release_bus();

    access(1, 0, 32'h103, 0, 3'b000, st);
    check("lb_103", rdata, 32'hFFFFFFDE);
    release_bus();
    access(1, 0, 32'h103, 0, 3'b100, st);
    check("lbu_103", rdata, 32'h000000DE);
    release_bus();
    access(1, 0, 32'h102, 0, 3'b001, st);
    check("lh_102", rdata, 32'hFFFFDEAD);
    release_bus();
    access(1, 0, 32'h100, 0, 3'b101, st);
    check("lhu_100", rdata, 32'h0000BEEF);
    release_bus();

    rd0 = rd_cnt;
    access(0, 1, 32'h101, 32'h00000055, 3'b000, st);
    check("sb_hit_stalls", 32'(st), 32'd0);
    check("sb_hit_mem_req", 32'(mem_req), 32'h0);
    release_bus();
    access(1, 0, 32'h100, 0, 3'b010, st);
    check("lw_after_sb", rdata, 32'hDEAD55EF);
    release_bus();

    // Misaligned and undefined-size accesses must not touch cache or memory.
    access(1, 0, 32'h102, 0, 3'b010, st);
    check("lw_mis_flag", 32'(misaligned), 32'h1);
    check("lw_mis_rdata", rdata, 32'h0);
    check("lw_mis_stall", 32'(st), 32'd0);
    check("lw_mis_mem_req", 32'(mem_req), 32'h0);
    release_bus();
    access(1, 0, 32'h101, 0, 3'b001, st);
    check("lh_mis_flag", 32'(misaligned), 32'h1);
    check("lh_mis_rdata", rdata, 32'h0);
    release_bus();
    access(1, 0, 32'h140, 0, 3'b011, st);
    check("undef_stall", 32'(st), 32'd0);
    check("undef_mis", 32'(misaligned), 32'h0);
    check("undef_mem_req", 32'(mem_req), 32'h0);
    release_bus();
    check("mis_no_reads", 32'(rd_cnt), 32'(rd0));
    access(1, 0, 32'h100, 0, 3'b010, st);
    check("mis_cache_kept", rdata, 32'hDEAD55EF);
    check("mis_cache_hit", 32'(st), 32'd0);
    release_bus();

    // Fill way1 of set 0 (clean victim), then force eviction of the dirty LRU line.
    wb0 = wb_addr_q.size();
    access(1, 0, 32'h140, 0, 3'b010, st);
    check("lw_140", rdata, 32'h11112222);
    check("lw_140_no_wb", 32'(wb_addr_q.size()), 32'(wb0));
    release_bus();
    access(1, 0, 32'h180, 0, 3'b010, st);
    check("lw_180", rdata, 32'h33334444);
    check("evict_wb_count", 32'(wb_addr_q.size()), 32'(wb0 + 1));
    if (wb_addr_q.size() > wb0) begin
      check("evict_wb_addr", wb_addr_q[wb0], 32'h100);
      check("evict_wb_data", wb_data_q[wb0], 32'hDEAD55EF);
    end
    check("evict_refill_addr", last_rd, 32'h180);
    release_bus();

    // Dirty both ways of set 0.
    access(0, 1, 32'h180, 32'hA5A5A5A5, 3'b010, st);
    release_bus();
    access(0, 1, 32'h142, 32'h00007777, 3'b001, st);
    release_bus();
    access(1, 0, 32'h140, 0, 3'b010, st);
    check("sh_142_merge", rdata, 32'h77772222);
    release_bus();

    wb0 = wb_addr_q.size();
    flush = 1'b1;
    #1;
    check("flush_stall", 32'(stall), 32'h1);
    @(negedge clk);
    flush = 1'b0;
    pulses = 0;
    for (int i = 0; i < 150; i++) begin
      #1;
      if (flush_done) pulses++;
      @(negedge clk);
    end
    check("flush_done_pulses", 32'(pulses), 32'd1);
    check("flush_wb_count", 32'(wb_addr_q.size()), 32'(wb0 + 2));
    if (wb_addr_q.size() >= wb0 + 2) begin
      check("flush_wb0_addr", wb_addr_q[wb0], 32'h180);
      check("flush_wb0_data", wb_data_q[wb0], 32'hA5A5A5A5);
      check("flush_wb1_addr", wb_addr_q[wb0 + 1], 32'h140);
      check("flush_wb1_data", wb_data_q[wb0 + 1], 32'h77772222);
    end

    // Lines stay valid but clean: hit, then a re-evict needs no write-back.
    access(1, 0, 32'h180, 0, 3'b010, st);
    check("post_flush_hit", 32'(st), 32'd0);
    check("post_flush_rdata", rdata, 32'hA5A5A5A5);
    release_bus();
    wb0 = wb_addr_q.size();
    access(1, 0, 32'h1C0, 0, 3'b010, st);
    check("reevict_rdata", rdata, 32'h55556666);
    check("reevict_no_wb", 32'(wb_addr_q.size()), 32'(wb0));
    release_bus();
    access(1, 0, 32'h180, 0, 3'b010, st);
    check("way0_survives", rdata, 32'hA5A5A5A5);
    check("way0_survives_hit", 32'(st), 32'd0);
    release_bus();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
